pcie_fifo_rd_sched: RTL and testbench

//  Read-side scheduler for the 128-bit read port of the video-to-PCIe async FIFO.

---
 rtl/pcie_fifo_rd_sched.sv | 169 ++++++++++++++++
 tb/tb_pcie_fifo_rd_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_fifo_rd_sched.sv
// Read-side burst scheduler between the video-to-PCIe async FIFO and the DMA TLP builder.
// Cuts the FIFO stream into req/ack-negotiated bursts and streams them with valid/ready/last.
`timescale 1ns/1ps
module pcie_fifo_rd_sched #(
  parameter int RD_DEPTH_WIDTH = 12,
  parameter int DATA_WIDTH     = 128,
  parameter int BURST_LEN      = 16,
  parameter int GAP_CYC        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [RD_DEPTH_WIDTH:0] fifo_rd_water_level,
  input  logic                    fifo_rd_empty,
  output logic                    fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  output logic                    dma_req,
  output logic [7:0]              dma_len,
  input  logic                    dma_ack,
  output logic                    dma_valid,
  output logic [DATA_WIDTH-1:0]   dma_data,
  output logic                    dma_last,
  input  logic                    dma_ready,
  output logic                    busy,
  output logic [31:0]             burst_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_GAP} state_e;

  localparam logic [7:0]              BurstLen8   = 8'(BURST_LEN);
  localparam logic [RD_DEPTH_WIDTH:0] BurstLenLvl = (RD_DEPTH_WIDTH+1)'(BURST_LEN);
  localparam logic [3:0]              GapLast     = 4'(GAP_CYC - 1);

  state_e                  state_q, state_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              rd_left_q, rd_left_d;
  logic [7:0]              beats_sent_q, beats_sent_d;
  logic [3:0]              gap_q, gap_d;
  logic [31:0]             burst_cnt_q, burst_cnt_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [1:0]              occ_q, occ_d;
  logic                    infl_q;
  logic [DATA_WIDTH-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;

  logic       pop, push, last_pop;
  logic [2:0] pending;

  assign dma_valid = (occ_q != 2'd0);
  assign dma_data  = buf0_q;
  assign dma_req   = (state_q == S_REQ);
  assign dma_len   = len_q;
  assign busy      = (state_q != S_IDLE);
  assign burst_cnt = burst_cnt_q;
  assign dma_last  = dma_valid && (beats_sent_q == len_q - 8'd1);

  assign pop      = dma_valid && dma_ready;
  assign push     = infl_q;
  assign last_pop = pop && (beats_sent_q == len_q - 8'd1);
  // Slots already committed after this cycle's pop; a new read must still fit in two entries.
  assign pending  = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};

  assign fifo_rd_en = (state_q == S_XFER) && (rd_left_q != 8'd0) && !fifo_rd_empty
                      && (pending < 3'd2);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    len_d        = len_q;
    rd_left_d    = rd_left_q;
    beats_sent_d = beats_sent_q;
    gap_d        = gap_q;
    burst_cnt_d  = burst_cnt_q;
    flush_pend_d = flush_pend_q;

    if (flush) begin
      flush_pend_d = 1'b1;
    end else if (state_q == S_IDLE && fifo_rd_empty && fifo_rd_water_level == '0) begin
      flush_pend_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable && fifo_rd_water_level >= BurstLenLvl) begin
          len_d   = BurstLen8;
          state_d = S_REQ;
        end else if (enable && flush_pend_q && fifo_rd_water_level != '0) begin
          len_d   = (fifo_rd_water_level < BurstLenLvl) ? fifo_rd_water_level[7:0] : BurstLen8;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (dma_ack) begin
          rd_left_d    = len_q;
          beats_sent_d = 8'd0;
          state_d      = S_XFER;
        end
      end
      S_XFER: begin
        rd_left_d = rd_left_q - {7'd0, fifo_rd_en};
        if (pop) beats_sent_d = beats_sent_q + 8'd1;
        if (last_pop) begin
          burst_cnt_d = burst_cnt_q + 32'd1;
          gap_d       = GapLast;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two-entry skid buffer; buf0 is always the head beat presented on dma_data.
  always_comb begin
    occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_rd_data;
        else               buf1_d = fifo_rd_data;
      end
      2'b01: buf0_d = buf1_q;
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rd_data;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the data buffer is reset as well, because dma_data is a port that must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q      <= S_IDLE;
      len_q        <= 8'd0;
      rd_left_q    <= 8'd0;
      beats_sent_q <= 8'd0;
      gap_q        <= 4'd0;
      burst_cnt_q  <= 32'd0;
      flush_pend_q <= 1'b0;
      occ_q        <= 2'd0;
      infl_q       <= 1'b0;
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_left_q    <= rd_left_d;
      beats_sent_q <= beats_sent_d;
      gap_q        <= gap_d;
      burst_cnt_q  <= burst_cnt_d;
      flush_pend_q <= flush_pend_d;
      occ_q        <= occ_d;
      infl_q       <= fifo_rd_en;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
    end
  end

endmodule

// File: tb/tb_pcie_fifo_rd_sched.sv
// Directed bench for pcie_fifo_rd_sched: FIFO model with a known word pattern, DMA side
// driven step by step, every beat compared against the FIFO order.
`timescale 1ns/1ps
module tb_pcie_fifo_rd_sched;
  localparam int DW = 128;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [AW:0]   fifo_rd_water_level;
  logic          fifo_rd_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          dma_req;
  logic [7:0]    dma_len;
  logic          dma_ack = 1'b0;
  logic          dma_valid;
  logic [DW-1:0] dma_data;
  logic          dma_last;
  logic          dma_ready = 1'b0;
  logic          busy;
  logic [31:0]   burst_cnt;

  int   avail = 0;
  int   rd_ptr = 0;
  logic force_empty = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  pcie_fifo_rd_sched #(.RD_DEPTH_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(16), .GAP_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .fifo_rd_water_level(fifo_rd_water_level), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .dma_req(dma_req), .dma_len(dma_len), .dma_ack(dma_ack),
    .dma_valid(dma_valid), .dma_data(dma_data), .dma_last(dma_last), .dma_ready(dma_ready),
    .busy(busy), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int k);
    return {4{32'hC0DE_0000 + 32'(k)}};
  endfunction

  // FIFO model: words word(0), word(1), ... ; data appears the cycle after fifo_rd_en.
  assign fifo_rd_water_level = (AW+1)'(avail - rd_ptr);
  assign fifo_rd_empty       = force_empty || (avail == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= word(rd_ptr);
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input integer obs, input integer exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one burst: acks the request, drives dma_ready, optionally forces FIFO empty
  // after empty_after reads and drops enable after drop_en_at beats, then checks the gap.
  task automatic run_burst(input int exp_len, input int ready_mode, input int empty_after,
                           input int drop_en_at, output int lat, output int span);
    int n = 0, start = rd_ptr, ack_cyc = -1, first_cyc = -1, last_cyc = -1, hold = 0, xc;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    for (int it = 0; it < 400 && n < exp_len; it++) begin
      tick();
      dma_ack = dma_req;
      if (dma_req && ack_cyc < 0) begin
        check("dma_len", integer'(dma_len), exp_len);
        ack_cyc = it;
      end
      xc = it - ack_cyc - 1;
      dma_ready = (ready_mode == 0 || ack_cyc < 0) ? 1'b1 : ((xc % 4) == 0 || (xc % 4) == 3);
      if (empty_after >= 0 && (rd_ptr - start) >= empty_after && hold < 6) begin
        force_empty = 1'b1;
        hold++;
      end else begin
        force_empty = 1'b0;
      end
      if (drop_en_at >= 0 && n == drop_en_at) enable = 1'b0;
      #1;
      if (fifo_rd_empty) check("rd_en_while_empty", integer'(fifo_rd_en), 0);
      check("outstanding_le_2", integer'((rd_ptr - start - n) <= 2), 1);
      if (prev_stall) begin
        check("stall_hold_valid", integer'(dma_valid), 1);
        check_data("stall_hold_data", dma_data, prev_data);
      end
      if (dma_valid) check("dma_last", integer'(dma_last), integer'(n == exp_len - 1));
      else           check("dma_last_idle", integer'(dma_last), 0);
      if (dma_valid && dma_ready) begin
        check_data("beat_data", dma_data, word(start + n));
        if (first_cyc < 0) first_cyc = it;
        last_cyc = it;
        n++;
      end
      prev_stall = dma_valid && !dma_ready;
      prev_data  = dma_data;
    end
    dma_ack     = 1'b0;
    dma_ready   = 1'b1;
    force_empty = 1'b0;
    check("beat_count", n, exp_len);
    lat  = first_cyc - ack_cyc;
    span = last_cyc - first_cyc;
    tick();
    check("gap1_busy", integer'(busy), 1);
    check("gap1_no_req", integer'(dma_req), 0);
    tick();
    check("gap2_busy", integer'(busy), 1);
    tick();
    check("gap_done_idle", integer'(busy), 0);
  endtask

  initial begin
    int lat, span, cnt;

    // Reset state
    #2;
    check("rst_dma_req", integer'(dma_req), 0);
    check("rst_dma_valid", integer'(dma_valid), 0);
    check("rst_dma_last", integer'(dma_last), 0);
    check("rst_busy", integer'(busy), 0);
    check("rst_burst_cnt", integer'(burst_cnt), 0);
    check("rst_dma_len", integer'(dma_len), 0);
    check_data("rst_dma_data", dma_data, '0);
    check("rst_fifo_rd_en", integer'(fifo_rd_en), 0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1: full burst at one beat per cycle
    avail     = 20;
    enable    = 1'b1;
    dma_ready = 1'b1;
    run_burst(16, 0, -1, -1, lat, span);
    check("t1_first_beat_latency", lat, 3);
    check("t1_consecutive_beats", span, 15);
    check("t1_burst_cnt", integer'(burst_cnt), 1);

    // 2: level below burst length waits; flush drains it with a short burst
    avail = rd_ptr + 15;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (dma_req) cnt++;
    end
    check("t2_no_req_below_burst", cnt, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_burst(15, 0, -1, -1, lat, span);
    check("t2_burst_cnt", integer'(burst_cnt), 2);
    repeat (10) tick();
    avail = rd_ptr + 5;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (dma_req) cnt++;
    end
    check("t2_flush_pend_cleared", cnt, 0);

    // 3: backpressure pattern 1,0,0,1
    avail = rd_ptr + 20;
    run_burst(16, 1, -1, -1, lat, span);
    check("t3_burst_cnt", integer'(burst_cnt), 3);

    // 4: FIFO goes empty after 5 reads, then recovers
    avail = rd_ptr + 20;
    run_burst(16, 0, 5, -1, lat, span);
    check("t4_burst_cnt", integer'(burst_cnt), 4);

    // 5: enable drops mid-burst; burst completes and nothing new starts
    avail = rd_ptr + 40;
    run_burst(16, 0, -1, 4, lat, span);
    check("t5_burst_cnt", integer'(burst_cnt), 5);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dma_req) cnt++;
    end
    check("t5_no_req_when_disabled", cnt, 0);

    // 6: reset in the middle of a transfer
    enable = 1'b1;
    for (int i = 0; i < 20 && !dma_req; i++) tick();
    check("t6_req_seen", integer'(dma_req), 1);
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    repeat (4) tick();
    check("t6_valid_before_reset", integer'(dma_valid), 1);
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("t6_rst_dma_valid", integer'(dma_valid), 0);
    check("t6_rst_dma_last", integer'(dma_last), 0);
    check("t6_rst_dma_req", integer'(dma_req), 0);
    check("t6_rst_busy", integer'(busy), 0);
    check("t6_rst_fifo_rd_en", integer'(fifo_rd_en), 0);
    check("t6_rst_burst_cnt", integer'(burst_cnt), 0);
    check("t6_rst_dma_len", integer'(dma_len), 0);
    check_data("t6_rst_dma_data", dma_data, '0);
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dma_valid || dma_last || dma_req) cnt++;
    end
    check("t6_no_spurious_after_reset", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
